// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: boot hold-off, load-use stall, redirect refill, drain/halt.
// Define FETCH_PERF_EN to add the stall/flush/bubble performance counters.
module fetch_ctrl #(
   parameter int IROM_LAT     = 1,
   parameter int BOOT_CYCLES  = 2,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en,
   input  logic        hazard_stall,
   input  logic        halt_req,
   input  logic        resume_req,
   output logic        pc_we,
   output logic        if_id_we,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        inst_valid,
   output logic        halted
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt,
   output logic [31:0] bubble_cnt
`endif
);

   localparam logic [2:0] ST_BOOT   = 3'd0;
   localparam logic [2:0] ST_RUN    = 3'd1;
   localparam logic [2:0] ST_REFILL = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_HALT   = 3'd4;

   localparam logic [3:0] BOOT_LOAD  = 4'(BOOT_CYCLES);
   localparam logic [3:0] LAT_LOAD   = 4'(IROM_LAT - 1);
   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);
   // A single-cycle IROM needs no refill window, so PC changes go straight back to RUN.
   localparam logic [2:0] FILL_STATE = (IROM_LAT == 1) ? ST_RUN : ST_REFILL;

   generate
      if (IROM_LAT < 1 || IROM_LAT > 4) begin : g_bad_irom_lat
         $error("fetch_ctrl: IROM_LAT must be 1..4");
      end
      if (BOOT_CYCLES < 1 || BOOT_CYCLES > 15) begin : g_bad_boot_cycles
         $error("fetch_ctrl: BOOT_CYCLES must be 1..15");
      end
      if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 7) begin : g_bad_drain_cycles
         $error("fetch_ctrl: DRAIN_CYCLES must be 1..7");
      end
   endgenerate

   logic [2:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       halted_q, halted_d;
   logic [3:0] cnt_dec;
   logic       cnt_last;

   assign cnt_dec  = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
   assign cnt_last = (cnt_q <= 4'd1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      inst_valid  = 1'b0;
      case (state_q)
         ST_BOOT: begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            cnt_d       = cnt_dec;
            if (cnt_last) begin
               state_d = FILL_STATE;
               cnt_d   = LAT_LOAD;
            end
         end
         ST_RUN: begin
            if (jump_en) begin
               pc_we       = 1'b1;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               state_d     = FILL_STATE;
               cnt_d       = LAT_LOAD;
            end else if (hazard_stall) begin
               id_ex_flush = 1'b1;
               inst_valid  = 1'b1;
            end else if (halt_req) begin
               if_id_flush = 1'b1;
               state_d     = ST_DRAIN;
               cnt_d       = DRAIN_LOAD;
            end else begin
               pc_we      = 1'b1;
               if_id_we   = 1'b1;
               inst_valid = 1'b1;
            end
         end
         ST_REFILL: begin
            if_id_flush = 1'b1;
            if (jump_en) begin
               pc_we       = 1'b1;
               id_ex_flush = 1'b1;
               cnt_d       = LAT_LOAD;
            end else begin
               cnt_d = cnt_dec;
               if (cnt_last) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_DRAIN: begin
            // A late redirect still updates the PC so resume starts at the right address.
            if_id_flush = 1'b1;
            cnt_d       = cnt_dec;
            if (jump_en) begin
               pc_we       = 1'b1;
               id_ex_flush = 1'b1;
            end
            if (cnt_last) begin
               state_d = ST_HALT;
            end
         end
         ST_HALT: begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (resume_req) begin
               state_d = FILL_STATE;
               cnt_d   = LAT_LOAD;
            end
         end
         default: begin
            state_d = ST_BOOT;
            cnt_d   = BOOT_LOAD;
         end
      endcase
      halted_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_BOOT;
         cnt_q    <= BOOT_LOAD;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         halted_q <= halted_d;
      end
   end

   assign halted = halted_q;

`ifdef FETCH_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (state_q == ST_RUN && !jump_en && hazard_stall) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (jump_en && (state_q == ST_RUN || state_q == ST_REFILL || state_q == ST_DRAIN)) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
      if (!inst_valid && state_q != ST_BOOT && state_q != ST_HALT) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q  <= 32'd0;
         flush_cnt_q  <= 32'd0;
         bubble_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign flush_cnt  = flush_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
